spi_master_multi: RTL and testbench
===================================

SPI_MASTER_MULTI -- requirements
Module: spi_master_multi

Interface
REQ-001 SHALL have parameter DATA_W, default 8, frame length in bits; legal values 4 to 32.
REQ-002 SHALL have parameter NUM_CS, default 4, number of chip-select outputs; legal values 1 to 8.
REQ-003 SHALL have parameter DIV_W, default 8, width of the clock-divider register.
REQ-004 SHALL have clk_i, input, 1, the single clock; all logic updates on its rising edge.
REQ-005 SHALL have aresetn_i, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have paddr_i input 8, psel_i input 1, penable_i input 1, pwrite_i input 1, and pwdata_i input 32; these form the APB request.
REQ-007 SHALL have pready_o output 1, prdata_o output 32, and pslverr_o output 1; these form the APB response.
REQ-008 SHALL have miso_i input 1, sclk_o output 1, mosi_o output 1, and cs_o output NUM_CS (active-low).
REQ-009 SHALL have irq_o, output, 1, a level interrupt equal to STATUS.done AND CTRL.ie.

Function
REQ-010 SHALL provide this register map:
- 0x00 CTRL: bit0 cpol, bit1 cpha, bit2 lsb_first, bits5:3 cs_sel, bit6 ie.
- 0x04 DIV: bits DIV_W-1:0.
- 0x08 TXDATA: a write loads the frame and starts a transfer.
- 0x0C RXDATA: read-only.
- 0x10 STATUS: bit0 busy, bit1 done.
REQ-011 SHALL complete every APB access with zero wait states: pready_o=1 whenever psel_i and penable_i are both high.
REQ-012 SHALL assert pslverr_o for any access to an unmapped address, for any write to CTRL, DIV, or TXDATA while busy, and for any cs_sel >= NUM_CS; these accesses have no effect and reads return 0.
REQ-013 SHALL clear STATUS.done on a read of STATUS or RXDATA; if the transfer-end and the clearing read fall in the same cycle, done SHALL be set.
REQ-014 SHALL produce an sclk_o half-period of DIV+1 clk_i cycles; DIV=0 gives clk_i/2.
REQ-015 SHALL run an FSM with states IDLE, SETUP, SHIFT, HOLD.
REQ-016 IDLE->SETUP SHALL occur on the accepted TXDATA write (the cycle after the access phase); in the same cycle busy=1 and cs_o[cs_sel]=0.
REQ-017 SETUP SHALL last one half-period, then go to SHIFT.
REQ-018 SHIFT SHALL produce 2*DATA_W sclk edges, then go to HOLD.
REQ-019 HOLD SHALL last one half-period, then go to IDLE; in that transition cs_o goes all-ones, busy=0, done=1, and RXDATA is updated.
REQ-020 sclk_o SHALL equal cpol in IDLE, SETUP, and HOLD.
REQ-021 When cpha=0, mosi_o SHALL present the first bit at SETUP entry, shift on each trailing edge, and sample miso_i on each leading edge.
REQ-022 When cpha=1, mosi_o SHALL shift on each leading edge and sample miso_i on each trailing edge.
REQ-023 When lsb_first=0, bit DATA_W-1 SHALL be sent first; when lsb_first=1, bit 0 SHALL be sent first. Receive order SHALL match transmit order.
REQ-024 Bits of pwdata_i above DATA_W-1 SHALL be ignored, and bits of RXDATA above DATA_W-1 SHALL read 0.
REQ-025 mosi_o SHALL be 0 in IDLE.
REQ-026 Full transfer latency, from TXDATA accept to done=1, SHALL be (2*DATA_W+2)*(DIV+1)+1 clk_i cycles.

Reset
REQ-027 While aresetn_i=0 at a clk_i edge, the following SHALL be reset:
- CTRL=0, DIV=0, RXDATA=0, busy=0, done=0, FSM=IDLE.
- sclk_o=0, mosi_o=0, cs_o all-ones, irq_o=0.
- pready_o=0, pslverr_o=0, prdata_o=0.
REQ-028 A reset during an active transfer SHALL abort it within that cycle, leave RXDATA=0, and not set done.

Structure
REQ-029 Register offsets, the CTRL field positions, and the FSM state enum SHALL live in shared package spi_pkg.
REQ-030 Half-period counting and leading/trailing-edge strobes SHALL be generated in one sub-module, spi_clk_gen, parameterised by DIV_W.

Verification
REQ-031 Mode 0 loopback (mosi_o tied to miso_i): DATA_W=8, DIV=1, CTRL=0x00, TXDATA=0xA5 -> mosi bits 1,0,1,0,0,1,0,1; RXDATA=0xA5; done asserts 37 cycles after accept.
REQ-032 Mode 3 with LSB first: CTRL=0x07 (cpol=1, cpha=1, lsb_first=1), miso_i driven with 0x3C LSB-first -> sclk idles high; RXDATA=0x3C; cs_o[0] is the only chip select low.
REQ-033 Busy protection: a write to TXDATA=0x11 during a transfer -> pslverr_o=1 and the frame in flight is unchanged; a CTRL write with cs_sel=5 when NUM_CS=4 -> pslverr_o=1 and CTRL unchanged.
REQ-034 Reset mid-transfer: aresetn_i=0 for 1 cycle at the 5th sclk edge -> next cycle cs_o=4'b1111, sclk_o=0, busy=0, done=0.
REQ-035 Done/irq: ie=1, transfer completes -> irq_o=1; a STATUS read returns 0x2 and the next cycle irq_o=0; DATA_W=32 with TXDATA=0xDEADBEEF loopback returns 0xDEADBEEF.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg
//   Shared definitions for the SPI master: APB register offsets, the CTRL
//   register layout and the transfer FSM state encoding.
//   No ports (package).
package spi_pkg;

  // APB register offsets
  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_DIV    = 8'h04;
  localparam logic [7:0] ADDR_TXDATA = 8'h08;
  localparam logic [7:0] ADDR_RXDATA = 8'h0C;
  localparam logic [7:0] ADDR_STATUS = 8'h10;

  // CTRL layout, LSB last: bit0 cpol, bit1 cpha, bit2 lsb_first,
  // bits5:3 cs_sel, bit6 ie.
  localparam int CTRL_W = 7;

  typedef struct packed {
    logic       ie;
    logic [2:0] cs_sel;
    logic       lsb_first;
    logic       cpha;
    logic       cpol;
  } ctrl_t;

  // Transfer FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_t;

endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen
//   Half-period timer and SCLK edge strobes for the SPI master.
//   Ports:
//     clk, rst_n   : clock, synchronous active-low reset
//     en           : timer runs while high, held at zero otherwise
//     shift        : high while SCLK edges are to be produced
//     div          : half-period is div+1 clk cycles
//     tick         : last cycle of the current half-period
//     lead, trail  : tick that produces a leading / trailing SCLK edge
//     phase        : 1 between a leading and the following trailing edge
module spi_clk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             shift,
  input  logic [DIV_W-1:0] div,
  output logic             tick,
  output logic             lead,
  output logic             trail,
  output logic             phase
);

  logic [DIV_W-1:0] cnt;

  assign tick  = en && (cnt == div);
  assign lead  = tick && shift && !phase;
  assign trail = tick && shift && phase;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (!en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else begin
      if (tick) cnt <= '0;
      else      cnt <= cnt + 1'b1;
      // An even number of edges per frame leaves phase back at 0 on exit.
      if (tick && shift) phase <= ~phase;
    end
  end

endmodule

// File: rtl/spi_master_multi.sv
// spi_master_multi
//   APB-programmed SPI master with NUM_CS chip selects, all four CPOL/CPHA
//   modes, MSB/LSB-first frames of DATA_W bits and a programmable divider.
//   Ports:
//     clk_i, aresetn_i            : clock, synchronous active-low reset
//     paddr_i .. pwdata_i         : APB request
//     pready_o, prdata_o, pslverr_o : APB response (zero wait states)
//     miso_i, sclk_o, mosi_o, cs_o  : SPI bus, cs_o active-low
//     irq_o                       : level interrupt, STATUS.done & CTRL.ie
//     state_o                     : current FSM state (debug observation)
//   APB handshake: a transfer is the access phase, the cycle where psel_i and
//   penable_i are both high; pready_o is high in exactly that cycle, read data
//   and pslverr_o are valid in it, and register writes take effect at the
//   rising edge that ends it.
module spi_master_multi
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8
) (
  input  logic              clk_i,
  input  logic              aresetn_i,
  input  logic [7:0]        paddr_i,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [31:0]       pwdata_i,
  output logic              pready_o,
  output logic [31:0]       prdata_o,
  output logic              pslverr_o,
  input  logic              miso_i,
  output logic              sclk_o,
  output logic              mosi_o,
  output logic [NUM_CS-1:0] cs_o,
  output logic              irq_o,
  output logic [1:0]        state_o
);

  localparam int EDGE_W = $clog2(2 * DATA_W);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

  spi_state_t        state;
  ctrl_t             ctrl;
  ctrl_t             new_ctrl;
  logic [DIV_W-1:0]  div;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] rx_data;
  logic              done;
  logic              mosi_q;
  logic [NUM_CS-1:0] cs_q;
  logic [EDGE_W-1:0] edge_cnt;

  logic        busy;
  logic        access;
  logic        acc_err;
  logic        cs_sel_bad;
  logic [31:0] rd_val;
  logic        wr_ok;
  logic        rd_ok;
  logic        start;
  logic        rd_clear;
  logic        set_done;

  logic tick;
  logic lead;
  logic trail;
  logic phase;
  logic drive;
  logic sample;

  logic [DATA_W-1:0] pop_src;
  logic [DATA_W-1:0] pop_rest;
  logic              pop_bit;
  logic [DATA_W-1:0] rx_next;

  logic unused_pwdata;
  assign unused_pwdata = ^pwdata_i;

  assign busy = (state != ST_IDLE);

  // ---------------------------------------------------------------- APB
  assign new_ctrl   = ctrl_t'(pwdata_i[CTRL_W-1:0]);
  assign cs_sel_bad = ({1'b0, new_ctrl.cs_sel} >= 4'(NUM_CS));

  always_comb begin
    acc_err = 1'b0;
    rd_val  = '0;
    case (paddr_i)
      ADDR_CTRL: begin
        acc_err = pwrite_i && (busy || cs_sel_bad);
        rd_val  = 32'(ctrl);
      end
      ADDR_DIV: begin
        acc_err = pwrite_i && busy;
        rd_val  = 32'(div);
      end
      ADDR_TXDATA: acc_err = pwrite_i && busy;
      ADDR_RXDATA: rd_val = 32'(rx_data);
      ADDR_STATUS: rd_val = {30'd0, done, busy};
      default:     acc_err = 1'b1;
    endcase
  end

  assign access    = aresetn_i && psel_i && penable_i;
  assign pready_o  = access;
  assign pslverr_o = access && acc_err;
  assign prdata_o  = (access && !pwrite_i && !acc_err) ? rd_val : 32'd0;

  assign wr_ok    = access && pwrite_i && !acc_err;
  assign rd_ok    = access && !pwrite_i && !acc_err;
  assign start    = wr_ok && (paddr_i == ADDR_TXDATA);
  assign rd_clear = rd_ok && ((paddr_i == ADDR_STATUS) || (paddr_i == ADDR_RXDATA));
  assign set_done = (state == ST_HOLD) && tick;

  // ---------------------------------------------------------------- timing
  spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
    .clk   (clk_i),
    .rst_n (aresetn_i),
    .en    (busy),
    .shift (state == ST_SHIFT),
    .div   (div),
    .tick  (tick),
    .lead  (lead),
    .trail (trail),
    .phase (phase)
  );

  // CPHA=0 changes data on trailing edges and samples on leading ones;
  // CPHA=1 is the reverse.
  assign drive  = ctrl.cpha ? lead  : trail;
  assign sample = ctrl.cpha ? trail : lead;

  // The next outgoing bit comes from the APB write data when a frame is
  // being loaded, otherwise from the shift register.
  assign pop_src  = (state == ST_IDLE) ? pwdata_i[DATA_W-1:0] : tx_sr;
  assign pop_bit  = ctrl.lsb_first ? pop_src[0] : pop_src[DATA_W-1];
  assign pop_rest = ctrl.lsb_first ? {1'b0, pop_src[DATA_W-1:1]}
                                   : {pop_src[DATA_W-2:0], 1'b0};
  assign rx_next  = ctrl.lsb_first ? {miso_i, rx_sr[DATA_W-1:1]}
                                   : {rx_sr[DATA_W-2:0], miso_i};

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk_i) begin
    if (!aresetn_i) begin
      state    <= ST_IDLE;
      ctrl     <= '0;
      div      <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      rx_data  <= '0;
      done     <= 1'b0;
      mosi_q   <= 1'b0;
      cs_q     <= '1;
      edge_cnt <= '0;
    end else begin
      if (wr_ok && (paddr_i == ADDR_CTRL)) ctrl <= new_ctrl;
      if (wr_ok && (paddr_i == ADDR_DIV))  div  <= pwdata_i[DIV_W-1:0];

      // A completing transfer wins over a clearing read in the same cycle.
      if (set_done)      done <= 1'b1;
      else if (rd_clear) done <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_SETUP;
            cs_q     <= ~(NUM_CS'(1) << ctrl.cs_sel);
            edge_cnt <= '0;
            rx_sr    <= '0;
            if (ctrl.cpha) begin
              // First bit appears on the first leading edge.
              tx_sr  <= pwdata_i[DATA_W-1:0];
              mosi_q <= 1'b0;
            end else begin
              tx_sr  <= pop_rest;
              mosi_q <= pop_bit;
            end
          end
        end
        ST_SETUP: begin
          if (tick) state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (drive) begin
            mosi_q <= pop_bit;
            tx_sr  <= pop_rest;
          end
          if (sample) rx_sr <= rx_next;
          if (tick) begin
            edge_cnt <= edge_cnt + 1'b1;
            if (edge_cnt == LAST_EDGE) state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (tick) begin
            state   <= ST_IDLE;
            cs_q    <= '1;
            mosi_q  <= 1'b0;
            rx_data <= rx_sr;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign sclk_o  = ctrl.cpol ^ phase;
  assign mosi_o  = mosi_q;
  assign cs_o    = cs_q;
  assign irq_o   = done && ctrl.ie;
  assign state_o = state;

endmodule

// File: tb/tb_spi_master_multi.sv
// tb_spi_master_multi
//   Directed and randomized checks of spi_master_multi: one 8-bit instance
//   talking to a behavioural SPI slave (or looped back), and one 32-bit
//   instance in loopback.
module tb_spi_master_multi;

  localparam int NA = 8;
  localparam int NB = 32;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic aresetn;

  // ---------------------------------------------------------------- APB / SPI wires
  logic [7:0]  paddr;
  logic        pwrite;
  logic        penable;
  logic [31:0] pwdata;
  logic        psel_a;
  logic        psel_b;

  logic        pready_a, pslverr_a, miso_a, sclk_a, mosi_a, irq_a;
  logic [31:0] prdata_a;
  logic [3:0]  cs_a;
  logic [1:0]  state_a;

  logic        pready_b, pslverr_b, miso_b, sclk_b, mosi_b, irq_b;
  logic [31:0] prdata_b;
  logic [3:0]  cs_b;
  logic [1:0]  state_b;

  logic loop_a;
  logic slave_miso;
  assign miso_a = loop_a ? mosi_a : slave_miso;
  assign miso_b = mosi_b;

  spi_master_multi #(.DATA_W(NA), .NUM_CS(4), .DIV_W(8)) dut_a (
    .clk_i(clk), .aresetn_i(aresetn),
    .paddr_i(paddr), .psel_i(psel_a), .penable_i(penable), .pwrite_i(pwrite), .pwdata_i(pwdata),
    .pready_o(pready_a), .prdata_o(prdata_a), .pslverr_o(pslverr_a),
    .miso_i(miso_a), .sclk_o(sclk_a), .mosi_o(mosi_a), .cs_o(cs_a),
    .irq_o(irq_a), .state_o(state_a)
  );

  spi_master_multi #(.DATA_W(NB), .NUM_CS(4), .DIV_W(8)) dut_b (
    .clk_i(clk), .aresetn_i(aresetn),
    .paddr_i(paddr), .psel_i(psel_b), .penable_i(penable), .pwrite_i(pwrite), .pwdata_i(pwdata),
    .pready_o(pready_b), .prdata_o(prdata_b), .pslverr_o(pslverr_b),
    .miso_i(miso_b), .sclk_o(sclk_b), .mosi_o(mosi_b), .cs_o(cs_b),
    .irq_o(irq_b), .state_o(state_b)
  );

  // ---------------------------------------------------------------- scoreboard
  int checks = 0;
  int passed = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- SPI slave model (dut_a)
  // Bit k of the frame on the wire is word[k] LSB-first or word[N-1-k] MSB-first.
  logic [7:0] slave_tx;
  logic [7:0] mosi_seen;
  bit s_cpol, s_cpha, s_lsb;
  int s_out_idx = 0;
  int s_in_idx  = 0;
  int s_edges   = 0;

  function automatic int wire_pos(input int k);
    return s_lsb ? k : NA - 1 - k;
  endfunction

  task automatic slave_present();
    if (s_out_idx < NA) slave_miso = slave_tx[wire_pos(s_out_idx)];
    s_out_idx++;
  endtask

  task automatic slave_capture();
    if (s_in_idx < NA) mosi_seen[wire_pos(s_in_idx)] = mosi_a;
    s_in_idx++;
  endtask

  always @(cs_a) begin
    if (cs_a != 4'hf) begin
      s_out_idx = 0;
      s_in_idx  = 0;
      s_edges   = 0;
      mosi_seen = '0;
      if (!s_cpha) slave_present();
    end
  end

  always @(sclk_a) begin
    if (cs_a != 4'hf) begin
      s_edges++;
      if (sclk_a != s_cpol) begin       // leading edge
        if (s_cpha) slave_present(); else slave_capture();
      end else begin                    // trailing edge
        if (!s_cpha) slave_present(); else slave_capture();
      end
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic apb(input bit b, input bit wr, input logic [7:0] addr, input logic [31:0] data,
                     output logic [31:0] rdata, output logic err);
    @(negedge clk);
    paddr   = addr;
    pwrite  = wr;
    pwdata  = data;
    penable = 1'b0;
    if (b) psel_b = 1'b1; else psel_a = 1'b1;
    @(negedge clk);
    penable = 1'b1;
    #1;
    chk("pready", b ? pready_b : pready_a, 32'd1);
    rdata = b ? prdata_b : prdata_a;
    err   = b ? pslverr_b : pslverr_a;
    @(posedge clk);
    #1;
    psel_a  = 1'b0;
    psel_b  = 1'b0;
    penable = 1'b0;
  endtask

  task automatic wr(input bit b, input logic [7:0] addr, input logic [31:0] data,
                    input logic exp_err, input string tag);
    logic [31:0] rdata;
    logic        err;
    apb(b, 1'b1, addr, data, rdata, err);
    chk({tag, "_wr_err"}, {31'd0, err}, {31'd0, exp_err});
  endtask

  task automatic rd(input bit b, input logic [7:0] addr, input logic [31:0] exp,
                    input logic exp_err, input string tag);
    logic [31:0] rdata;
    logic        err;
    apb(b, 1'b0, addr, 32'd0, rdata, err);
    chk({tag, "_rd_err"}, {31'd0, err}, {31'd0, exp_err});
    chk({tag, "_rd_data"}, rdata, exp);
  endtask

  // Counts rising edges after the accept edge until the FSM is idle again.
  task automatic wait_idle(input bit b, output int n);
    n = 0;
    while (((b ? state_b : state_a) != 2'd0) && (n < 5000)) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  function automatic int lat(input int n, input int div);
    return (2 * n + 2) * (div + 1) + 1;
  endfunction

  task automatic xfer_a(input logic [6:0] ctrl, input int div, input logic [7:0] tx,
                        input logic [7:0] sdata, input bit loop, input string tag);
    logic [3:0] exp_cs;
    int n;
    s_cpol   = ctrl[0];
    s_cpha   = ctrl[1];
    s_lsb    = ctrl[2];
    slave_tx = sdata;
    loop_a   = loop;
    wr(0, 8'h04, 32'(div), 1'b0, {tag, "_div"});
    wr(0, 8'h00, {25'd0, ctrl}, 1'b0, {tag, "_ctrl"});
    chk({tag, "_sclk_idle"}, {31'd0, sclk_a}, {31'd0, ctrl[0]});
    wr(0, 8'h08, {24'd0, tx}, 1'b0, {tag, "_tx"});
    exp_cs = 4'hf;
    exp_cs[ctrl[5:3]] = 1'b0;
    chk({tag, "_cs_active"}, {28'd0, cs_a}, {28'd0, exp_cs});
    wait_idle(0, n);
    chk({tag, "_latency"}, n + 1, lat(NA, div));
    chk({tag, "_cs_release"}, {28'd0, cs_a}, 32'hf);
    chk({tag, "_mosi_idle"}, {31'd0, mosi_a}, 32'd0);
    chk({tag, "_sclk_end"}, {31'd0, sclk_a}, {31'd0, ctrl[0]});
    chk({tag, "_edges"}, s_edges, 2 * NA);
    chk({tag, "_mosi_bits"}, {24'd0, mosi_seen}, {24'd0, tx});
    rd(0, 8'h10, 32'h2, 1'b0, {tag, "_status"});
    rd(0, 8'h0c, {24'd0, loop ? tx : sdata}, 1'b0, {tag, "_rx"});
    rd(0, 8'h10, 32'h0, 1'b0, {tag, "_status_clr"});
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int n;
    logic [6:0]  c;
    logic [31:0] w;
    logic [7:0]  t;
    logic [7:0]  s;

    aresetn    = 1'b0;
    paddr      = 8'h10;
    pwrite     = 1'b0;
    pwdata     = '0;
    psel_a     = 1'b1;
    psel_b     = 1'b0;
    penable    = 1'b1;
    loop_a     = 1'b0;
    slave_miso = 1'b0;
    slave_tx   = '0;
    mosi_seen  = '0;

    // Reset values, with an APB access held active during reset.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", {28'd0, cs_a}, 32'hf);
    chk("rst_sclk", {31'd0, sclk_a}, 32'd0);
    chk("rst_mosi", {31'd0, mosi_a}, 32'd0);
    chk("rst_irq", {31'd0, irq_a}, 32'd0);
    chk("rst_pready", {31'd0, pready_a}, 32'd0);
    chk("rst_pslverr", {31'd0, pslverr_a}, 32'd0);
    chk("rst_prdata", prdata_a, 32'd0);
    chk("rst_state", {30'd0, state_a}, 32'd0);
    chk("rst_cs_b", {28'd0, cs_b}, 32'hf);
    psel_a  = 1'b0;
    penable = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;

    rd(0, 8'h00, 32'h0, 1'b0, "rst_ctrl");
    rd(0, 8'h04, 32'h0, 1'b0, "rst_div");
    rd(0, 8'h0c, 32'h0, 1'b0, "rst_rx");
    rd(0, 8'h10, 32'h0, 1'b0, "rst_status");

    // Mode 0 loopback, 0xA5, DIV=1: done 37 cycles after accept.
    xfer_a(7'h00, 1, 8'hA5, 8'h00, 1'b1, "mode0_loop");

    // Mode 3, LSB first, slave returns 0x3C.
    t = 8'($urandom);
    xfer_a(7'h07, 1, t, 8'h3C, 1'b0, "mode3_lsb");

    // Randomized modes, chip selects, dividers and data.
    for (int i = 0; i < 6; i++) begin
      c = {1'b0, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
      t = 8'($urandom);
      s = 8'($urandom);
      xfer_a(c, $urandom_range(0, 3), t, s, 1'($urandom_range(0, 1)), "rand");
    end

    // Busy protection: the frame in flight must not change.
    s_cpol = 1'b0; s_cpha = 1'b1; s_lsb = 1'b0;
    s = 8'($urandom);
    slave_tx = s;
    loop_a   = 1'b0;
    wr(0, 8'h04, 32'd3, 1'b0, "busy_div");
    wr(0, 8'h00, 32'h0A, 1'b0, "busy_ctrl");
    wr(0, 8'h08, 32'h5A, 1'b0, "busy_tx");
    wr(0, 8'h08, 32'h11, 1'b1, "busy_tx_again");
    wr(0, 8'h00, 32'h01, 1'b1, "busy_ctrl_again");
    wr(0, 8'h04, 32'h00, 1'b1, "busy_div_again");
    rd(0, 8'h00, 32'h0A, 1'b0, "busy_ctrl_kept");
    chk("busy_cs", {28'd0, cs_a}, 32'hd);
    wait_idle(0, n);
    chk("busy_finished", {30'd0, state_a}, 32'd0);
    chk("busy_mosi_bits", {24'd0, mosi_seen}, 32'h5A);
    rd(0, 8'h0c, {24'd0, s}, 1'b0, "busy_rx");
    wr(0, 8'h00, 32'h28, 1'b1, "cs_sel5");
    rd(0, 8'h00, 32'h0A, 1'b0, "cs_sel5_ctrl_kept");
    rd(0, 8'h04, 32'h3, 1'b0, "div_kept");
    rd(0, 8'h14, 32'h0, 1'b1, "unmapped_rd");
    wr(0, 8'h02, 32'hFF, 1'b1, "unmapped_wr");

    // Done/irq: ie=1, interrupt until STATUS is read.
    loop_a = 1'b1;
    s_cpol = 1'b0; s_cpha = 1'b0; s_lsb = 1'b0;
    wr(0, 8'h04, 32'd0, 1'b0, "irq_div");
    wr(0, 8'h00, 32'h40, 1'b0, "irq_ctrl");
    t = 8'($urandom);
    wr(0, 8'h08, {24'd0, t}, 1'b0, "irq_tx");
    chk("irq_low_busy", {31'd0, irq_a}, 32'd0);
    n = 0;
    while (!irq_a && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("irq_latency", n + 1, lat(NA, 0));
    chk("irq_high", {31'd0, irq_a}, 32'd1);
    rd(0, 8'h10, 32'h2, 1'b0, "irq_status");
    chk("irq_cleared", {31'd0, irq_a}, 32'd0);
    rd(0, 8'h0c, {24'd0, t}, 1'b0, "irq_rx");

    // 32-bit loopback, random modes.
    for (int i = 0; i < 2; i++) begin
      int d;
      d = $urandom_range(0, 2);
      w = $urandom;
      wr(1, 8'h04, 32'(d), 1'b0, "b_div");
      wr(1, 8'h00, {29'd0, 3'($urandom_range(0, 7))}, 1'b0, "b_ctrl");
      wr(1, 8'h08, w, 1'b0, "b_tx");
      chk("b_cs", {28'd0, cs_b}, 32'he);
      wait_idle(1, n);
      chk("b_latency", n + 1, lat(NB, d));
      rd(1, 8'h10, 32'h2, 1'b0, "b_status");
      rd(1, 8'h0c, w, 1'b0, "b_rx");
    end

    // 0xDEADBEEF with a STATUS read landing on the completion cycle.
    wr(1, 8'h04, 32'd0, 1'b0, "deadbeef_div");
    wr(1, 8'h00, 32'h0, 1'b0, "deadbeef_ctrl");
    wr(1, 8'h08, 32'hDEADBEEF, 1'b0, "deadbeef_tx");
    repeat (lat(NB, 0) - 3) @(posedge clk);
    rd(1, 8'h10, 32'h1, 1'b0, "same_cycle_status");
    rd(1, 8'h10, 32'h2, 1'b0, "same_cycle_done_kept");
    rd(1, 8'h0c, 32'hDEADBEEF, 1'b0, "deadbeef_rx");

    // Reset at the 5th SCLK edge aborts the transfer.
    loop_a = 1'b1;
    wr(0, 8'h04, 32'd1, 1'b0, "abort_div");
    wr(0, 8'h00, 32'h0, 1'b0, "abort_ctrl");
    wr(0, 8'h08, 32'hC3, 1'b0, "abort_tx");
    n = 0;
    while (s_edges < 5 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("abort_reached_edge5", s_edges, 5);
    @(negedge clk);
    aresetn = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_cs", {28'd0, cs_a}, 32'hf);
    chk("abort_sclk", {31'd0, sclk_a}, 32'd0);
    chk("abort_mosi", {31'd0, mosi_a}, 32'd0);
    chk("abort_state", {30'd0, state_a}, 32'd0);
    chk("abort_irq", {31'd0, irq_a}, 32'd0);
    @(negedge clk);
    aresetn = 1'b1;
    rd(0, 8'h10, 32'h0, 1'b0, "abort_status");
    rd(0, 8'h0c, 32'h0, 1'b0, "abort_rx");
    rd(1, 8'h0c, 32'h0, 1'b0, "abort_rx_b");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
